// File: rtl/countdown_timer_pkg.sv
// Shared types for the loadable down-counter: FSM state encoding and default width.
package countdown_pkg;

  localparam int CD_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cd_state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Load/decrement/status bundle for countdown_timer; master drives requests, slave is the timer.
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  import countdown_pkg::*;

  // Load handshake: a transfer happens in any cycle where load_valid && load_ready are both high
  // at the rising edge; load_value is sampled only then, and load_valid may be held or dropped freely.
  logic             clr;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             dec;
  logic             reload_en;
  logic [WIDTH-1:0] out;
  logic             running;
  logic             done;
  cd_state_t        dbg_state;

  modport master (
    output clr, load_valid, load_value, dec, reload_en,
    input  load_ready, out, running, done, dbg_state
  );

  modport slave (
    input  clr, load_valid, load_value, dec, reload_en,
    output load_ready, out, running, done, dbg_state
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse on expiry and optional auto-reload.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_DEFAULT_WIDTH
) (
  input  logic               aclk,
  input  logic               arst,
  countdown_timer_if.slave   bus
);

  cd_state_t        state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             done_q, done_n;
  logic             running_q;
  logic             handshake;

  assign bus.load_ready = (state_q == IDLE) && !bus.clr;
  assign handshake      = bus.load_valid && bus.load_ready;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      count_q   <= count_n;
      reload_q  <= reload_n;
      done_q    <= done_n;
      running_q <= (state_n == RUN);
    end
  end

  // clr beats a load, a load beats dec; dec only acts in RUN, where count is always nonzero.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    done_n   = 1'b0;
    if (bus.clr) begin
      state_n = IDLE;
      count_n = '0;
    end else if (handshake) begin
      count_n  = bus.load_value;
      reload_n = bus.load_value;
      if (bus.load_value != '0) begin
        state_n = RUN;
      end else begin
        done_n = 1'b1;
      end
    end else if ((state_q == RUN) && bus.dec) begin
      if (count_q > WIDTH'(1)) begin
        count_n = count_q - WIDTH'(1);
      end else begin
        done_n = 1'b1;
        if (bus.reload_en) begin
          count_n = reload_q;
        end else begin
          count_n = '0;
          state_n = IDLE;
        end
      end
    end
  end

  assign bus.out       = count_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: per-cycle expected outputs go into a queue, a monitor checks them.
module tb_countdown_timer;
  import countdown_pkg::*;

  localparam int W = 8;

  logic aclk;
  logic arst;
  int   total;
  int   bad;

  logic [W+2:0] exp_q[$];

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .aclk (aclk),
    .arst (arst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [W+2:0] got, input logic [W+2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got out=%0d run=%0b done=%0b rdy=%0b, want out=%0d run=%0b done=%0b rdy=%0b",
               name, got[W+2:3], got[2], got[1], got[0], want[W+2:3], want[2], want[1], want[0]);
    end
  endtask

  function automatic logic [W+2:0] sample();
    return {bus.out, bus.running, bus.done, bus.load_ready};
  endfunction

  // Monitor: every cycle with a pending expectation is compared just after the edge.
  always @(posedge aclk) begin
    logic [W+2:0] want;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check("cycle", sample(), want);
    end
  end

  // ---------------- driver ----------------
  // Drives one cycle of inputs and records the outputs expected after the following edge.
  task automatic step(input logic v, input logic [W-1:0] val, input logic d, input logic re,
                      input logic c, input logic [W-1:0] e_out, input logic e_run, input logic e_done);
    @(negedge aclk);
    bus.load_valid = v;
    bus.load_value = val;
    bus.dec        = d;
    bus.reload_en  = re;
    bus.clr        = c;
    exp_q.push_back({e_out, e_run, e_done, ~e_run & ~c});
  endtask

  task automatic drain();
    int budget;
    budget = 50;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge aclk);
      budget--;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    arst  = 1'b1;
    bus.clr = 1'b0; bus.load_valid = 1'b0; bus.load_value = '0;
    bus.dec = 1'b0; bus.reload_en = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    arst = 1'b0;
    #1;
    check("reset", sample(), {8'd0, 1'b0, 1'b0, 1'b1});
    total++;
    if (bus.dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE);
    end

    //      v  val    d  re c   out   run done
    // Load 3, dec held, no reload
    step(1, 8'd3, 1, 0, 0, 8'd3, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd2, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd1, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd0, 0, 1);
    step(0, 8'd0, 1, 0, 0, 8'd0, 0, 0);
    // Load 2 with auto-reload
    step(1, 8'd2, 1, 1, 0, 8'd2, 1, 0);
    step(0, 8'd0, 1, 1, 0, 8'd1, 1, 0);
    step(0, 8'd0, 1, 1, 0, 8'd2, 1, 1);
    step(0, 8'd0, 1, 1, 0, 8'd1, 1, 0);
    step(0, 8'd0, 1, 1, 0, 8'd2, 1, 1);
    step(0, 8'd0, 1, 1, 0, 8'd1, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd0, 0, 1);
    // Load 0
    step(1, 8'd0, 0, 0, 0, 8'd0, 0, 1);
    step(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
    // Load 5, clr together with a dec
    step(1, 8'd5, 0, 0, 0, 8'd5, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd4, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd3, 1, 0);
    step(1, 8'd7, 1, 0, 1, 8'd0, 0, 0);
    // Load 1 with reload: back-to-back done
    step(1, 8'd1, 0, 1, 0, 8'd1, 1, 0);
    step(0, 8'd0, 1, 1, 0, 8'd1, 1, 1);
    step(0, 8'd0, 1, 1, 0, 8'd1, 1, 1);
    step(0, 8'd0, 1, 0, 0, 8'd0, 0, 1);
    // clr on a terminal dec suppresses done
    step(1, 8'd1, 0, 0, 0, 8'd1, 1, 0);
    step(0, 8'd0, 1, 0, 1, 8'd0, 0, 0);
    step(0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
    // Load 4, dec every other cycle, load_valid during RUN ignored
    step(1, 8'd4, 0, 0, 0, 8'd4, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd3, 1, 0);
    step(1, 8'd9, 0, 0, 0, 8'd3, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd2, 1, 0);
    step(1, 8'd9, 0, 0, 0, 8'd2, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd1, 1, 0);
    step(0, 8'd0, 0, 0, 0, 8'd1, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd0, 0, 1);
    // Full-width load
    step(1, 8'd255, 1, 0, 0, 8'd255, 1, 0);
    step(0, 8'd0, 1, 0, 0, 8'd254, 1, 0);
    step(0, 8'd0, 0, 0, 0, 8'd254, 1, 0);
    drain();

    // arst mid-RUN returns to reset values immediately
    @(negedge aclk);
    arst = 1'b1;
    #1;
    check("arst_mid_run", sample(), {8'd0, 1'b0, 1'b0, 1'b1});
    @(negedge aclk);
    arst = 1'b0;
    step(0, 8'd0, 1, 0, 0, 8'd0, 0, 0);
    step(1, 8'd2, 0, 0, 0, 8'd2, 1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
